// File: rtl/latch_xm_pkg.sv
// Shared decode constants for the execute-to-memory pipeline latch.
// These are the opcode, ALU-op, rstatus and register-index values that the
// latch and its control decoder both need.
package latch_xm_pkg;

    // Primary opcodes (insn[31:27])
    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    // R-type ALU ops (insn[6:2])
    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;

    // Status codes written to rstatus on arithmetic overflow
    localparam int RSTATUS_W = 2;
    localparam logic [RSTATUS_W-1:0] RSTATUS_ADD  = 2'd1;
    localparam logic [RSTATUS_W-1:0] RSTATUS_ADDI = 2'd2;
    localparam logic [RSTATUS_W-1:0] RSTATUS_SUB  = 2'd3;

    // Architected register indices with fixed roles
    localparam int REG_RSTATUS = 30;
    localparam int REG_RA      = 31;

    // True for opcodes whose result is written back to the register file
    function automatic logic writes_reg(input logic [4:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_ADDI) || (opcode == OP_LW) ||
               (opcode == OP_JAL)   || (opcode == OP_SETX);
    endfunction

endpackage

// File: rtl/latch_xm_ctrl_decode.sv
// Combinational control decode for the X/M latch: works out the final
// destination register (including the jal/setx fixed targets and the
// rstatus overflow rewrite) and whether writeback is enabled.
module xm_ctrl_decode
    import latch_xm_pkg::*;
#(
    parameter int RSTATUS_REG = REG_RSTATUS
) (
    input  logic [31:0]          insn,
    input  logic                 overflow,
    output logic [4:0]           rd,
    output logic                 reg_we_raw,
    output logic                 ovf_sub,
    output logic [RSTATUS_W-1:0] ovf_code
);

    logic [4:0] opcode;
    logic [4:0] alu_op;
    logic [4:0] field_rd;
    logic [4:0] base_rd;
    logic       is_radd;
    logic       is_rsub;
    logic       is_addi;
    logic       unused_insn_bits;

    assign opcode   = insn[31:27];
    assign field_rd = insn[26:22];
    assign alu_op   = insn[6:2];

    assign unused_insn_bits = ^{insn[21:7], insn[1:0]};

    assign is_radd = (opcode == OP_RTYPE) && (alu_op == ALU_ADD);
    assign is_rsub = (opcode == OP_RTYPE) && (alu_op == ALU_SUB);
    assign is_addi = (opcode == OP_ADDI);

    // Only add, addi and sub report overflow; other opcodes ignore it
    always_comb begin
        ovf_sub  = 1'b0;
        ovf_code = '0;
        if (overflow) begin
            if (is_radd) begin
                ovf_sub  = 1'b1;
                ovf_code = RSTATUS_ADD;
            end else if (is_addi) begin
                ovf_sub  = 1'b1;
                ovf_code = RSTATUS_ADDI;
            end else if (is_rsub) begin
                ovf_sub  = 1'b1;
                ovf_code = RSTATUS_SUB;
            end
        end
    end

    // jal links into $ra and setx targets rstatus; everything else uses the rd field
    always_comb begin
        base_rd = field_rd;
        if (opcode == OP_JAL) begin
            base_rd = 5'(REG_RA);
        end else if (opcode == OP_SETX) begin
            base_rd = 5'(REG_RSTATUS);
        end
    end

    assign rd         = ovf_sub ? 5'(RSTATUS_REG) : base_rd;
    assign reg_we_raw = writes_reg(opcode) && (rd != 5'd0);

endmodule

// File: rtl/latch_xm.sv
// Execute-to-memory pipeline register. Captures the execute-stage
// instruction and datapath values, applies the rstatus overflow rewrite,
// and presents decoded memory-stage controls. Supports stall, flush and a
// retired-instruction counter.
module latch_xm
    import latch_xm_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 12,
    parameter int RSTATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              x_valid,
    input  logic [31:0]       x_insn,
    input  logic [DATA_W-1:0] x_alu_result,
    input  logic [DATA_W-1:0] x_operandB,
    input  logic              x_overflow,
    output logic              m_valid,
    output logic [31:0]       m_insn,
    output logic [4:0]        m_opcode,
    output logic [DATA_W-1:0] m_alu_result,
    output logic [DATA_W-1:0] m_operandB,
    output logic [ADDR_W-1:0] m_address_dmem,
    output logic [DATA_W-1:0] m_d_dmem,
    output logic              m_wren,
    output logic [4:0]        m_rd,
    output logic              m_reg_we,
    output logic              m_is_load,
    output logic [31:0]       retired_count
);

    logic                 valid_q;
    logic [31:0]          insn_q;
    logic [DATA_W-1:0]    result_q;
    logic [DATA_W-1:0]    operand_b_q;
    logic [4:0]           rd_q;
    logic                 reg_we_q;
    logic [31:0]          count_q;

    logic [4:0]           dec_rd;
    logic                 dec_reg_we_raw;
    logic                 dec_ovf_sub;
    logic [RSTATUS_W-1:0] dec_ovf_code;

    xm_ctrl_decode #(
        .RSTATUS_REG (RSTATUS_REG)
    ) u_decode (
        .insn       (x_insn),
        .overflow   (x_valid & x_overflow),
        .rd         (dec_rd),
        .reg_we_raw (dec_reg_we_raw),
        .ovf_sub    (dec_ovf_sub),
        .ovf_code   (dec_ovf_code)
    );

    // Pipeline register: flush inserts a bubble, stall holds, otherwise capture
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            insn_q      <= '0;
            result_q    <= '0;
            operand_b_q <= '0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
        end else if (flush) begin
            valid_q     <= 1'b0;
            insn_q      <= '0;
            result_q    <= '0;
            operand_b_q <= '0;
            rd_q        <= '0;
            reg_we_q    <= 1'b0;
        end else if (!stall) begin
            valid_q     <= x_valid;
            insn_q      <= x_insn;
            result_q    <= dec_ovf_sub ? DATA_W'(dec_ovf_code) : x_alu_result;
            operand_b_q <= x_operandB;
            rd_q        <= dec_rd;
            reg_we_q    <= x_valid & dec_reg_we_raw;
        end
    end

    // Retired-instruction counter: counts real instructions entering memory, wraps naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else if (!flush && !stall && x_valid) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign m_valid        = valid_q;
    assign m_insn         = insn_q;
    assign m_opcode       = insn_q[31:27];
    assign m_alu_result   = result_q;
    assign m_operandB     = operand_b_q;
    assign m_address_dmem = result_q[ADDR_W-1:0];
    assign m_d_dmem       = operand_b_q;
    assign m_rd           = rd_q;
    assign m_wren         = valid_q && (m_opcode == OP_SW);
    assign m_reg_we       = valid_q && reg_we_q;
    assign m_is_load      = valid_q && (m_opcode == OP_LW);
    assign retired_count  = count_q;

endmodule

// File: tb/tb_latch_xm.sv
// Scoreboard testbench for latch_xm. The stimulus process pushes the
// hand-computed expected memory-stage view for every issued cycle; a
// separate monitor pops and compares on the following falling edge.
module tb_latch_xm;
    import latch_xm_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 12;

    logic              clock;
    logic              reset;
    logic              stall;
    logic              flush;
    logic              x_valid;
    logic [31:0]       x_insn;
    logic [DATA_W-1:0] x_alu_result;
    logic [DATA_W-1:0] x_operandB;
    logic              x_overflow;
    logic              m_valid;
    logic [31:0]       m_insn;
    logic [4:0]        m_opcode;
    logic [DATA_W-1:0] m_alu_result;
    logic [DATA_W-1:0] m_operandB;
    logic [ADDR_W-1:0] m_address_dmem;
    logic [DATA_W-1:0] m_d_dmem;
    logic              m_wren;
    logic [4:0]        m_rd;
    logic              m_reg_we;
    logic              m_is_load;
    logic [31:0]       retired_count;

    typedef struct {
        logic        valid;
        logic [31:0] insn;
        logic [4:0]  opcode;
        logic [31:0] result;
        logic [31:0] operand_b;
        logic [11:0] address;
        logic [31:0] d;
        logic        wren;
        logic [4:0]  rd;
        logic        reg_we;
        logic        is_load;
        logic [31:0] count;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        last_exp;
    exp_t        zero_exp;
    logic [31:0] exp_count;
    int          total;
    int          bad;
    int          pop_idx;

    latch_xm #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .RSTATUS_REG (30)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .flush          (flush),
        .x_valid        (x_valid),
        .x_insn         (x_insn),
        .x_alu_result   (x_alu_result),
        .x_operandB     (x_operandB),
        .x_overflow     (x_overflow),
        .m_valid        (m_valid),
        .m_insn         (m_insn),
        .m_opcode       (m_opcode),
        .m_alu_result   (m_alu_result),
        .m_operandB     (m_operandB),
        .m_address_dmem (m_address_dmem),
        .m_d_dmem       (m_d_dmem),
        .m_wren         (m_wren),
        .m_rd           (m_rd),
        .m_reg_we       (m_reg_we),
        .m_is_load      (m_is_load),
        .retired_count  (retired_count)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] mk_insn(input logic [4:0] op, input logic [4:0] rd,
                                            input logic [4:0] alu);
        return {op, rd, 15'b0, alu, 2'b0};
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t e, input string tag);
        checkField({tag, ".m_valid"},        32'(m_valid),        32'(e.valid));
        checkField({tag, ".m_insn"},         m_insn,              e.insn);
        checkField({tag, ".m_opcode"},       32'(m_opcode),       32'(e.opcode));
        checkField({tag, ".m_alu_result"},   m_alu_result,        e.result);
        checkField({tag, ".m_operandB"},     m_operandB,          e.operand_b);
        checkField({tag, ".m_address_dmem"}, 32'(m_address_dmem), 32'(e.address));
        checkField({tag, ".m_d_dmem"},       m_d_dmem,            e.d);
        checkField({tag, ".m_wren"},         32'(m_wren),         32'(e.wren));
        checkField({tag, ".m_rd"},           32'(m_rd),           32'(e.rd));
        checkField({tag, ".m_reg_we"},       32'(m_reg_we),       32'(e.reg_we));
        checkField({tag, ".m_is_load"},      32'(m_is_load),      32'(e.is_load));
        checkField({tag, ".retired_count"},  retired_count,       e.count);
    endtask

    // Drive one cycle and queue what the memory stage must show after the edge
    task automatic applyStimulus(input logic s, input logic f, input logic v,
                                 input logic [31:0] insn, input logic [31:0] res,
                                 input logic [31:0] opb, input logic ovf,
                                 input logic [4:0] e_rd, input logic [31:0] e_res,
                                 input logic e_wren, input logic e_we, input logic e_load);
        exp_t e;
        stall        = s;
        flush        = f;
        x_valid      = v;
        x_insn       = insn;
        x_alu_result = res;
        x_operandB   = opb;
        x_overflow   = ovf;
        e            = zero_exp;
        if (f) begin
            e.count = exp_count;
        end else if (s) begin
            e = last_exp;
        end else begin
            if (v) exp_count = exp_count + 32'd1;
            e.valid     = v;
            e.insn      = insn;
            e.opcode    = insn[31:27];
            e.result    = e_res;
            e.operand_b = opb;
            e.address   = e_res[11:0];
            e.d         = opb;
            e.wren      = e_wren;
            e.rd        = e_rd;
            e.reg_we    = e_we;
            e.is_load   = e_load;
            e.count     = exp_count;
        end
        @(posedge clock);
        exp_q.push_back(e);
        last_exp = e;
        #1;
    endtask

    // Monitor: compare the oldest queued expectation against the DUT each falling edge
    initial begin
        exp_t cur;
        pop_idx = 0;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                checkOutput(cur, $sformatf("v%0d", pop_idx));
                pop_idx++;
            end
        end
    end

    initial begin
        total     = 0;
        bad       = 0;
        exp_count = '0;
        zero_exp  = '{default: '0};
        last_exp  = zero_exp;
        reset     = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        x_valid   = 1'b0;
        x_insn    = '0;
        x_alu_result = '0;
        x_operandB   = '0;
        x_overflow   = 1'b0;

        // Reset held low with random inputs: everything must read zero
        for (int i = 0; i < 3; i++) begin
            stall        = 1'($urandom);
            flush        = 1'($urandom);
            x_valid      = 1'b1;
            x_insn       = $urandom;
            x_alu_result = $urandom;
            x_operandB   = $urandom;
            x_overflow   = 1'($urandom);
            @(negedge clock);
            checkOutput(zero_exp, "reset");
        end
        #2 reset = 1'b1;

        // sw: dmem write with address from result, data from operandB
        applyStimulus(0, 0, 1, mk_insn(OP_SW, 5'd3, 5'd0), 32'h0000_0ABC, 32'hDEAD_BEEF, 0,
                      5'd3, 32'h0000_0ABC, 1, 0, 0);
        // Overflow rewrites: add -> 1, addi -> 2, sub -> 3, all into $r30
        applyStimulus(0, 0, 1, mk_insn(OP_RTYPE, 5'd5, ALU_ADD), 32'h8000_0000, 32'h1111_1111, 1,
                      5'd30, 32'd1, 0, 1, 0);
        applyStimulus(0, 0, 1, mk_insn(OP_ADDI, 5'd6, 5'd0), 32'h8000_0004, 32'h2222_2222, 1,
                      5'd30, 32'd2, 0, 1, 0);
        applyStimulus(0, 0, 1, mk_insn(OP_RTYPE, 5'd9, ALU_SUB), 32'h7FFF_FFF0, 32'h3333_3333, 1,
                      5'd30, 32'd3, 0, 1, 0);
        // lw ignores overflow
        applyStimulus(0, 0, 1, mk_insn(OP_LW, 5'd4, 5'd0), 32'h0000_0100, 32'h4444_4444, 1,
                      5'd4, 32'h0000_0100, 0, 1, 1);
        // lw rd=7 then a 3-cycle stall: outputs and counter hold
        applyStimulus(0, 0, 1, mk_insn(OP_LW, 5'd7, 5'd0), 32'h0000_0044, 32'h0000_0055, 0,
                      5'd7, 32'h0000_0044, 0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 1, mk_insn(OP_SW, 5'd2, 5'd0), 32'h0000_0999, 32'h0000_0777, 0,
                          5'd0, 32'h0, 0, 0, 0);
        end
        // stall and flush together: flush wins
        applyStimulus(1, 1, 1, mk_insn(OP_SW, 5'd2, 5'd0), 32'h0000_0999, 32'h0000_0777, 0,
                      5'd0, 32'h0, 0, 0, 0);
        // Writes to $r0 are suppressed; jal -> $r31, setx -> $r30
        applyStimulus(0, 0, 1, mk_insn(OP_RTYPE, 5'd0, ALU_ADD), 32'h0000_0012, 32'h0, 0,
                      5'd0, 32'h0000_0012, 0, 0, 0);
        applyStimulus(0, 0, 1, mk_insn(OP_JAL, 5'd2, 5'd0), 32'h0000_0020, 32'h0, 0,
                      5'd31, 32'h0000_0020, 0, 1, 0);
        applyStimulus(0, 0, 1, mk_insn(OP_SETX, 5'd1, 5'd0), 32'h0000_00AA, 32'h0, 0,
                      5'd30, 32'h0000_00AA, 0, 1, 0);
        // Two bubbles: datapath captured, controls masked, counter unchanged
        applyStimulus(0, 0, 0, mk_insn(OP_SW, 5'd0, 5'd0), 32'h0000_0333, 32'h0000_0444, 0,
                      5'd0, 32'h0000_0333, 0, 0, 0);
        applyStimulus(0, 0, 0, mk_insn(OP_LW, 5'd0, 5'd0), 32'h0000_0555, 32'h0000_0666, 0,
                      5'd0, 32'h0000_0555, 0, 0, 0);
        applyStimulus(0, 0, 1, mk_insn(OP_RTYPE, 5'd1, ALU_ADD), 32'h0000_0005, 32'h0, 0,
                      5'd1, 32'h0000_0005, 0, 1, 0);
        // Flush alone: bubble, counter stays at 10 valid captures
        applyStimulus(0, 1, 1, mk_insn(OP_ADDI, 5'd2, 5'd0), 32'h0000_0007, 32'h0, 0,
                      5'd0, 32'h0, 0, 0, 0);
        checkField("count_after_ten", exp_count, 32'd10);

        // Preload the counter to all-ones, then one capture must wrap it to zero
        @(negedge clock);
        #1 force dut.count_q = 32'hFFFF_FFFF;
        #1 release dut.count_q;
        exp_count = 32'hFFFF_FFFF;
        applyStimulus(0, 0, 1, mk_insn(OP_SW, 5'd0, 5'd0), 32'h0000_0ABC, 32'hCAFE_F00D, 0,
                      5'd0, 32'h0000_0ABC, 1, 0, 0);

        // Asynchronous reset between edges while a sw is presented
        @(negedge clock);
        #2 reset = 1'b0;
        #1 checkOutput(zero_exp, "async_reset");
        stall   = 1'b0;
        flush   = 1'b0;
        x_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 checkField("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
